bram_address_generator: RTL and testbench
=========================================

# bram_address_generator

Free-running BRAM address source that feeds the write-enable stage. Produces a wrapping address ramp with a run-time programmable frame length. Also produces a `restart` pulse that is re-timed to land exactly on the last address of a frame, so the downstream `write_enable` arms and then starts its one-frame write at address 0. Address, end-of-frame tick and restart share one fixed pipeline delay that matches BRAM/ADC latency.

## Interface
- `BRAM_WIDTH`, 5: address width; frame length is at most 2^BRAM_WIDTH.
- `DELAY`, 3: register stages between internal counter and outputs; legal range 1..16.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `en`  in  1: count enable; low holds the counter.
- `cfg_last`  in  BRAM_WIDTH: last address of a frame (frame length = cfg_last+1).
- `restart_in`  in  1: restart request, single-cycle pulse or level.
- `address`  out  BRAM_WIDTH: delayed address ramp (drives `write_enable.address`).
- `restart`  out  1: re-timed restart pulse (drives `write_enable.restart`).
- `last`  out  1: end-of-frame tick, high when `address` is the frame's last address.

## Operation
- Internal state:
  - `cnt` (BRAM_WIDTH).
  - `last_sh`: shadow of `cfg_last`.
  - `pending` (1).
  - Three DELAY-deep shift registers for `cnt`, `wrap_c` and `rst_c`.
- `wrap_c = en && (cnt == last_sh)`, combinational.
- Counter, when `en` = 1:
  - `cnt` <= 0 if `wrap_c`, else `cnt`+1.
  - Unsigned, BRAM_WIDTH bits, never exceeds `last_sh`.
- Counter, when `en` = 0: `cnt` and `last_sh` hold.
- `last_sh` loads `cfg_last` only on `wrap_c`. Mid-frame changes take effect from the next frame. Lowering `cfg_last` below the current `cnt` cannot cause overrun.
- Restart re-timing:
  - `rst_c = wrap_c && (pending || restart_in)`.
  - `pending` sets on `restart_in && !rst_c` and clears on `rst_c`.
  - Multiple requests before a wrap collapse into one pulse.
- Output pipeline:
  - Shifts every cycle regardless of `en`.
  - `address` = `cnt` delayed DELAY cycles.
  - `last` = `wrap_c` delayed DELAY cycles.
  - `restart` = `rst_c` delayed DELAY cycles.
- Invariants:
  - `restart` is never high unless `last` is high in the same cycle.
  - `restart` is never high two cycles in a row unless `cfg_last` = 0.

## Timing
- Reset values: `cnt`=0, `last_sh`=0, `pending`=0, all pipeline stages 0. So `address`=0, `last`=0, `restart`=0 while `rst` is high and for DELAY cycles after release.
- First enabled cycle after reset: `cnt`=0 equals `last_sh`=0, so it is a wrap. `last_sh` loads `cfg_last` there, and any pending or concurrent request issues there.
- Latency:
  - Counter to `address`/`last`/`restart` = DELAY cycles.
  - `restart_in` to `restart`: DELAY cycles if the request coincides with a wrap. Otherwise the wait until the next wrap, plus DELAY.
- With `en` held high, the cycle after `restart`=1 shows `address`=0.
- `cfg_last`=0: every enabled cycle wraps, `address` stays 0, `last` stays high. A request issues immediately with no pending state.
- `restart_in` while `en`=0: latched in `pending`, issued at the first wrap after `en` returns.
- `rst` asserted mid-frame or with `pending` set: all state clears asynchronously. The request is dropped and no `restart` is emitted afterwards.
- `en` dropped in the cycle `cnt`==`last_sh`: no wrap. `pending` is kept and `cnt` holds at last.

## Test plan
- Reset then `en`=1, `cfg_last`=31, DELAY=3 -> `address` 0 for cycles 0..3. The first wrap yields one `last` pulse at cycle 3. After that `address` counts 0,1,..,31 and `last`=1 exactly when `address`=31, every 32 cycles.
- `restart_in` pulsed when `cnt`=6 -> `pending` set. `restart`=1 for one cycle together with `address`=31 and `last`=1; the next cycle `address`=0. Then drive a `write_enable` model and check it writes 32 words starting at address 0.
- `restart_in` in the same cycle as `cnt`=31 -> `restart` exactly 3 cycles later. Three requests within one frame -> exactly one `restart` pulse.
- `cfg_last` changed 31->7 while `cnt`=20 -> frame completes to 31, the next frame wraps at 7. `address` never exceeds 31 and never shows 8..31 after the change takes effect.
- `en` low for 10 cycles at `cnt`=12 with `restart_in` pulsed during the hold -> `address` holds 12 after 3 cycles. On resume the count continues 13.., and `restart` appears with the next `address`=31.
- `rst` pulsed asynchronously mid-frame with `pending` set -> outputs 0 immediately. The following frame ramps from 0 with no `restart` pulse.

Source files
------------

// File: rtl/bram_address_generator.sv
// Wrapping BRAM address ramp with a programmable frame length. A restart
// request is held until the end of the current frame, so the restart pulse
// lands on the frame's last address. Address, end-of-frame tick and restart
// pass through the same DELAY-stage pipeline to match BRAM/ADC latency.
module bram_address_generator #(
  parameter int BRAM_WIDTH = 5,
  parameter int DELAY      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [BRAM_WIDTH-1:0] cfg_last,
  input  logic                  restart_in,
  output logic [BRAM_WIDTH-1:0] address,
  output logic                  restart,
  output logic                  last
);

  logic [BRAM_WIDTH-1:0] cnt;
  logic [BRAM_WIDTH-1:0] last_sh;
  logic                  pending;
  logic                  wrap_c;
  logic                  rst_c;

  logic [BRAM_WIDTH-1:0] cnt_pipe [DELAY];
  logic [DELAY-1:0]      wrap_pipe;
  logic [DELAY-1:0]      rst_pipe;

  // End-of-frame detect and restart issue, both only on an enabled wrap.
  always_comb begin
    wrap_c = en && (cnt == last_sh);
    rst_c  = wrap_c && (pending || restart_in);
  end

  // Frame counter. The frame length is shadowed at the wrap, so a new
  // cfg_last never truncates or overruns the frame that is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      last_sh <= '0;
    end else if (en) begin
      if (wrap_c) begin
        cnt     <= '0;
        last_sh <= cfg_last;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Outstanding restart request; several requests in a frame collapse into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (rst_c) begin
      pending <= 1'b0;
    end else if (restart_in) begin
      pending <= 1'b1;
    end
  end

  // Output pipeline: runs every cycle, independent of en, so all three
  // outputs stay aligned to each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) begin
        cnt_pipe[i] <= '0;
      end
      wrap_pipe <= '0;
      rst_pipe  <= '0;
    end else begin
      cnt_pipe[0]  <= cnt;
      wrap_pipe[0] <= wrap_c;
      rst_pipe[0]  <= rst_c;
      for (int i = 1; i < DELAY; i++) begin
        cnt_pipe[i]  <= cnt_pipe[i-1];
        wrap_pipe[i] <= wrap_pipe[i-1];
        rst_pipe[i]  <= rst_pipe[i-1];
      end
    end
  end

  assign address = cnt_pipe[DELAY-1];
  assign last    = wrap_pipe[DELAY-1];
  assign restart = rst_pipe[DELAY-1];

endmodule

// File: tb/tb_bram_address_generator.sv
// Self-checking bench for bram_address_generator: a directed vector table,
// hand-written corner sequences and a randomized run against a frame-level
// reference model whose output latency is a FIFO of DLY entries.
module tb_bram_address_generator;

  localparam int W   = 5;
  localparam int DLY = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [W-1:0] cfg_last = '0;
  logic         restart_in = 1'b0;
  logic [W-1:0] address;
  logic         restart;
  logic         last;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_cnt;
  int m_last;
  bit m_pend;
  int qa[$];
  bit ql[$];
  bit qr[$];

  typedef struct {
    logic         en;
    logic [W-1:0] cfg;
    logic         rin;
    logic [W-1:0] a;
    logic         l;
    logic         r;
  } vec_t;

  vec_t tbl[16];

  bram_address_generator #(.BRAM_WIDTH(W), .DELAY(DLY)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_last   (cfg_last),
    .restart_in (restart_in),
    .address    (address),
    .restart    (restart),
    .last       (last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_last = 0;
    m_pend = 0;
    qa.delete();
    ql.delete();
    qr.delete();
    for (int i = 0; i < DLY; i++) begin
      qa.push_back(0);
      ql.push_back(1'b0);
      qr.push_back(1'b0);
    end
  endtask

  // One clock of the frame model: a frame ends when the position reaches the
  // frame's last address; a request is outstanding until a frame ends.
  task automatic model_edge();
    bit end_of_frame;
    bit issue;
    end_of_frame = en && (m_cnt == m_last);
    issue        = end_of_frame && (m_pend || restart_in);
    qa.push_back(m_cnt);
    ql.push_back(end_of_frame);
    qr.push_back(issue);
    qa.delete(0);
    ql.delete(0);
    qr.delete(0);
    if (en) begin
      if (end_of_frame) begin
        m_cnt  = 0;
        m_last = int'(cfg_last);
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    m_pend = (m_pend || restart_in) && !end_of_frame;
  endtask

  task automatic compare_outputs();
    chk("address", 32'(address), 32'(qa[0]));
    chk("last", 32'(last), 32'(ql[0]));
    chk("restart", 32'(restart), 32'(qr[0]));
    chk("restart_implies_last", 32'(restart & ~last), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic wait_cnt(input int v);
    int k;
    k = 0;
    while (m_cnt != v && k < 100) begin
      tick();
      k++;
    end
    if (m_cnt != v) chk("wait_cnt_timeout", 32'(m_cnt), 32'(v));
  endtask

  // Asserts rst between clock edges and holds it across one rising edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_address", 32'(address), 32'd0);
    chk("async_rst_last", 32'(last), 32'd0);
    chk("async_rst_restart", 32'(restart), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int seen;
    int at_addr;
    int pulses;
    int maxa;
    int k;

    tbl[0]  = '{1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 5'd2, 1'b0, 5'd1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 5'd2, 1'b0, 5'd1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 5'd2, 1'b1, 5'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 5'd2, 1'b0, 5'd1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1};

    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_address", 32'(address), 32'd0);
    chk("reset_last", 32'(last), 32'd0);
    chk("reset_restart", 32'(restart), 32'd0);
    rst = 1'b0;

    // directed vector table, short frame (cfg_last=2)
    for (int i = 0; i < 16; i++) begin
      en         = tbl[i].en;
      cfg_last   = tbl[i].cfg;
      restart_in = tbl[i].rin;
      tick();
      chk($sformatf("tbl%0d_address", i), 32'(address), 32'(tbl[i].a));
      chk($sformatf("tbl%0d_last", i), 32'(last), 32'(tbl[i].l));
      chk($sformatf("tbl%0d_restart", i), 32'(restart), 32'(tbl[i].r));
    end
    restart_in = 1'b0;

    // full 32-word frames; request at cnt=6 drives a write_enable model
    en       = 1'b1;
    cfg_last = 5'd31;
    wait_cnt(0);
    wait_cnt(6);
    restart_in = 1'b1;
    tick();
    restart_in = 1'b0;
    seen    = 0;
    at_addr = -1;
    k       = 0;
    while (!seen && k < 100) begin
      tick();
      if (restart === 1'b1) begin
        seen    = 1;
        at_addr = int'(address);
      end
      k++;
    end
    chk("restart_seen", 32'(seen), 32'd1);
    chk("restart_at_last_addr", 32'(at_addr), 32'd31);
    for (int w = 0; w < 32; w++) begin
      tick();
      chk("we_write_addr", 32'(address), 32'(w));
    end

    // request coinciding with the wrap appears exactly DLY cycles later
    wait_cnt(31);
    restart_in = 1'b1;
    tick();
    restart_in = 1'b0;
    chk("wrap_req_d1", 32'(restart), 32'd0);
    tick();
    chk("wrap_req_d2", 32'(restart), 32'd0);
    tick();
    chk("wrap_req_d3", 32'(restart), 32'd1);

    // three requests in one frame collapse into a single pulse
    wait_cnt(2);
    pulses = 0;
    for (int c = 0; c < 70; c++) begin
      restart_in = (m_cnt == 2 || m_cnt == 10 || m_cnt == 20) && c < 32;
      tick();
      if (restart === 1'b1) pulses++;
    end
    restart_in = 1'b0;
    chk("collapse_pulses", 32'(pulses), 32'd1);

    // shrink the frame mid-frame: current frame finishes at 31, then 0..7
    wait_cnt(20);
    cfg_last = 5'd7;
    seen     = 0;
    maxa     = 0;
    at_addr  = -1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (seen && int'(address) > maxa) maxa = int'(address);
      if (!seen && last === 1'b1) begin
        seen    = 1;
        at_addr = int'(address);
      end
    end
    chk("shrink_old_frame_end", 32'(at_addr), 32'd31);
    chk("shrink_max_address", 32'(maxa), 32'd7);

    // hold with en low at cnt=12, request during the hold
    cfg_last = 5'd31;
    wait_cnt(0);
    wait_cnt(12);
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      restart_in = (c == 3);
      tick();
    end
    restart_in = 1'b0;
    chk("hold_address", 32'(address), 32'd12);
    en = 1'b1;
    seen    = 0;
    at_addr = -1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!seen && restart === 1'b1) begin
        seen    = 1;
        at_addr = int'(address);
      end
    end
    chk("hold_restart_seen", 32'(seen), 32'd1);
    chk("hold_restart_addr", 32'(at_addr), 32'd31);

    // async reset mid-frame with a request outstanding drops the request
    wait_cnt(5);
    restart_in = 1'b1;
    tick();
    restart_in = 1'b0;
    tick();
    tick();
    async_reset();
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (restart === 1'b1) pulses++;
    end
    chk("post_reset_no_restart", 32'(pulses), 32'd0);

    // randomized run against the frame model
    for (int c = 0; c < 3000; c++) begin
      en         = ($urandom_range(0, 9) != 0);
      restart_in = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 39) == 0) begin
        cfg_last = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3))
                                               : W'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
